// File: rtl/product_shift_reg.sv
// Low-order product shift register for the add/shift multiplier: collects STEP bits per
// accepted shift, with preload, serial-out tap, shift counter, FULL and sticky OVF.
module product_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP = 1,
  parameter int unsigned DIR = 0,
  localparam int unsigned NSHIFT = WIDTH / STEP,
  localparam int unsigned CW = $clog2(NSHIFT + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR_ACC,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic             SFT_IN,
  input  logic [STEP-1:0]  D_OUT,
  output logic [WIDTH-1:0] SHIFTREG,
  output logic [STEP-1:0]  SER_OUT,
  output logic [CW-1:0]    SHIFT_CNT,
  output logic             FULL,
  output logic             OVF
);

  if (WIDTH < 2 || STEP == 0 || (WIDTH % STEP) != 0 || DIR > 1) begin : gen_bad_params
    $error("product_shift_reg: illegal WIDTH/STEP/DIR combination");
  end

  logic [WIDTH-1:0] shiftreg_q, shiftreg_d, shifted;
  logic [STEP-1:0]  ser_q, ser_d, displaced;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;

  // A single shift replaces the whole register when STEP == WIDTH.
  if (STEP == WIDTH) begin : gen_whole
    assign shifted   = D_OUT;
    assign displaced = shiftreg_q;
  end else if (DIR == 0) begin : gen_right
    assign shifted   = {D_OUT, shiftreg_q[WIDTH-1:STEP]};
    assign displaced = shiftreg_q[STEP-1:0];
  end else begin : gen_left
    assign shifted   = {shiftreg_q[WIDTH-STEP-1:0], D_OUT};
    assign displaced = shiftreg_q[WIDTH-1:WIDTH-STEP];
  end

  always_comb begin
    shiftreg_d = shiftreg_q;
    ser_d      = ser_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    ovf_d      = ovf_q;
    if (CLR_ACC) begin
      shiftreg_d = '0;
      ser_d      = '0;
      cnt_d      = '0;
      full_d     = 1'b0;
      ovf_d      = 1'b0;
    end else if (LOAD) begin
      shiftreg_d = LOAD_DATA;
      cnt_d      = '0;
      full_d     = 1'b0;
      ovf_d      = 1'b0;
    end else if (SFT_IN) begin
      if (full_q) begin
        ovf_d = 1'b1;
      end else begin
        shiftreg_d = shifted;
        ser_d      = displaced;
        cnt_d      = cnt_q + CW'(1);
        // FULL is registered alongside the counter reaching NSHIFT.
        full_d     = (cnt_q == CW'(NSHIFT - 1));
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shiftreg_q <= '0;
      ser_q      <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      shiftreg_q <= shiftreg_d;
      ser_q      <= ser_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
    end
  end

  assign SHIFTREG  = shiftreg_q;
  assign SER_OUT   = ser_q;
  assign SHIFT_CNT = cnt_q;
  assign FULL      = full_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_product_shift_reg.sv
// Directed bench: right-shift STEP=1 instance and left-shift STEP=2 instance on shared controls.
module tb_product_shift_reg;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CLR_ACC = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] LOAD_DATA = 8'h00;
  logic       SFT_IN = 1'b0;
  logic [0:0] d_r = 1'b0;
  logic [1:0] d_l = 2'b00;

  logic [7:0] reg_r, reg_l;
  logic [0:0] ser_r;
  logic [1:0] ser_l;
  logic [3:0] cnt_r;
  logic [2:0] cnt_l;
  logic       full_r, full_l, ovf_r, ovf_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  product_shift_reg #(.WIDTH(8), .STEP(1), .DIR(0)) u_dut_r (
    .CLK(CLK), .RST(RST), .CLR_ACC(CLR_ACC), .LOAD(LOAD), .LOAD_DATA(LOAD_DATA),
    .SFT_IN(SFT_IN), .D_OUT(d_r), .SHIFTREG(reg_r), .SER_OUT(ser_r),
    .SHIFT_CNT(cnt_r), .FULL(full_r), .OVF(ovf_r)
  );

  product_shift_reg #(.WIDTH(8), .STEP(2), .DIR(1)) u_dut_l (
    .CLK(CLK), .RST(RST), .CLR_ACC(CLR_ACC), .LOAD(LOAD), .LOAD_DATA(LOAD_DATA),
    .SFT_IN(SFT_IN), .D_OUT(d_l), .SHIFTREG(reg_l), .SER_OUT(ser_l),
    .SHIFT_CNT(cnt_l), .FULL(full_l), .OVF(ovf_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear();
    CLR_ACC = 1'b1;
    step();
    CLR_ACC = 1'b0;
  endtask

  task automatic shift_r(input logic b);
    d_r = b;
    SFT_IN = 1'b1;
    step();
    SFT_IN = 1'b0;
  endtask

  task automatic shift_l(input logic [1:0] b);
    d_l = b;
    SFT_IN = 1'b1;
    step();
    SFT_IN = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat_a;
    logic [7:0] pat_b;
    logic [1:0] pat_l [4];
    pat_a = 8'b0100_1101;  // D_OUT sequence 1,0,1,1,0,0,1,0 read LSB-first
    pat_b = 8'b1001_0110;  // D_OUT sequence 0,1,1,0,1,0,0,1 read LSB-first
    pat_l[0] = 2'b11; pat_l[1] = 2'b00; pat_l[2] = 2'b10; pat_l[3] = 2'b01;

    // Reset state held while RST is high
    step(); step();
    check("rst_reg", 32'(reg_r), 32'h00);
    check("rst_ser", 32'(ser_r), 32'h0);
    check("rst_cnt", 32'(cnt_r), 32'h0);
    check("rst_full", 32'(full_r), 32'h0);
    check("rst_ovf", 32'(ovf_r), 32'h0);
    RST = 1'b0;

    // Right shift, STEP=1: fill with 8 shifts
    clear();
    for (int i = 0; i < 8; i++) begin
      shift_r(pat_a[i]);
      if (i == 6) begin
        check("r_cnt7", 32'(cnt_r), 32'd7);
        check("r_full_early", 32'(full_r), 32'h0);
      end
    end
    check("r_fill_reg", 32'(reg_r), 32'h4D);
    check("r_fill_cnt", 32'(cnt_r), 32'd8);
    check("r_fill_full", 32'(full_r), 32'h1);
    check("r_fill_ovf", 32'(ovf_r), 32'h0);
    check("r_fill_ser", 32'(ser_r), 32'h0);

    // Ninth shift is rejected and sets OVF
    shift_r(1'b1);
    check("r_ovf_reg", 32'(reg_r), 32'h4D);
    check("r_ovf_cnt", 32'(cnt_r), 32'd8);
    check("r_ovf_flag", 32'(ovf_r), 32'h1);
    step();
    check("r_ovf_sticky", 32'(ovf_r), 32'h1);

    clear();
    check("clr_reg", 32'(reg_r), 32'h00);
    check("clr_cnt", 32'(cnt_r), 32'h0);
    check("clr_full", 32'(full_r), 32'h0);
    check("clr_ovf", 32'(ovf_r), 32'h0);

    // LOAD beats a simultaneous SFT_IN
    LOAD = 1'b1; LOAD_DATA = 8'hA5; SFT_IN = 1'b1; d_r = 1'b1;
    step();
    LOAD = 1'b0; SFT_IN = 1'b0;
    check("load_reg", 32'(reg_r), 32'hA5);
    check("load_cnt", 32'(cnt_r), 32'h0);
    check("load_ser", 32'(ser_r), 32'h0);
    shift_r(1'b0);
    check("load_shift_reg", 32'(reg_r), 32'h52);
    check("load_shift_ser", 32'(ser_r), 32'h1);
    check("load_shift_cnt", 32'(cnt_r), 32'd1);

    // Left shift, STEP=2: fills in exactly 4 shifts
    clear();
    for (int i = 0; i < 4; i++) begin
      shift_l(pat_l[i]);
      if (i == 2) check("l_full_early", 32'(full_l), 32'h0);
    end
    check("l_fill_reg", 32'(reg_l), 32'hC9);
    check("l_fill_cnt", 32'(cnt_l), 32'd4);
    check("l_fill_full", 32'(full_l), 32'h1);
    check("l_fill_ser", 32'(ser_l), 32'h0);
    shift_l(2'b11);
    check("l_ovf_reg", 32'(reg_l), 32'hC9);
    check("l_ovf_flag", 32'(ovf_l), 32'h1);

    // Asynchronous reset between edges after 3 shifts
    clear();
    for (int i = 0; i < 3; i++) shift_r(1'b1);
    check("ar_pre_reg", 32'(reg_r), 32'hE0);
    #2;
    RST = 1'b1;
    #1;
    check("ar_reg", 32'(reg_r), 32'h00);
    check("ar_ser", 32'(ser_r), 32'h0);
    check("ar_cnt", 32'(cnt_r), 32'h0);
    check("ar_full", 32'(full_r), 32'h0);
    check("ar_ovf", 32'(ovf_r), 32'h0);
    step();
    RST = 1'b0;
    for (int i = 0; i < 8; i++) shift_r(pat_b[i]);
    check("ar_fill_reg", 32'(reg_r), 32'h96);
    check("ar_fill_cnt", 32'(cnt_r), 32'd8);
    check("ar_fill_full", 32'(full_r), 32'h1);

    // CLR_ACC has priority over LOAD
    CLR_ACC = 1'b1; LOAD = 1'b1; LOAD_DATA = 8'hFF;
    step();
    CLR_ACC = 1'b0; LOAD = 1'b0;
    check("prio_reg_r", 32'(reg_r), 32'h00);
    check("prio_reg_l", 32'(reg_l), 32'h00);
    check("prio_full", 32'(full_r), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/product_shift_reg.md
Name: product_shift_reg

Overview:
- Parametrised successor to the multiplier's 8-bit low-product shift register.
- Collects the low-order product bits emitted by the add/shift datapath, STEP bits per shift, into a WIDTH-bit register.
- Adds a selectable shift direction, parallel preload, a registered serial-out tap, a shift counter with FULL flag, and sticky overflow detection.
- Sits beside the accumulator; the multiplier controller drives SFT_IN/CLR_ACC and uses FULL as its done condition.

Parameters:
- WIDTH, 8: register width in bits; must be ≥ 2.
- STEP, 1: bits inserted per shift; must divide WIDTH exactly (radix-2^STEP multipliers).
- DIR, 0: 0 = right shift (new bits enter at MSB end); 1 = left shift (new bits enter at LSB end).
- NSHIFT (localparam), WIDTH/STEP: number of shifts that fills the register.
- CW (localparam), $clog2(NSHIFT+1): counter width.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous active-high reset.
- CLR_ACC  in  1  synchronous clear of register, counter and flags.
- LOAD  in  1  synchronous parallel load of LOAD_DATA.
- LOAD_DATA  in  WIDTH  preload value.
- SFT_IN  in  1  shift enable.
- D_OUT  in  STEP  bits shifted in (D_OUT[STEP-1] is the most significant).
- SHIFTREG  out  WIDTH  register contents.
- SER_OUT  out  STEP  registered copy of the bits displaced by the most recent accepted shift.
- SHIFT_CNT  out  CW  accepted shifts since the last clear/load.
- FULL  out  1  high when SHIFT_CNT == NSHIFT.
- OVF  out  1  sticky; set when SFT_IN arrives while FULL.

Behaviour:
- RST high, asynchronous: SHIFTREG = 0, SER_OUT = 0, SHIFT_CNT = 0, FULL = 0, OVF = 0. These values hold while RST is high.
- All other updates occur on the CLK rising edge. Priority is CLR_ACC > LOAD > SFT_IN.
- CLR_ACC: all outputs go to their reset values.
- LOAD (CLR_ACC low):
  - SHIFTREG = LOAD_DATA.
  - SHIFT_CNT = 0, FULL = 0, OVF = 0.
  - SER_OUT unchanged.
  - A simultaneous SFT_IN is ignored.
- SFT_IN (no CLR_ACC/LOAD) with FULL low, an accepted shift:
  - DIR=0: SHIFTREG = {D_OUT, SHIFTREG[WIDTH-1:STEP]}; SER_OUT = old SHIFTREG[STEP-1:0].
  - DIR=1: SHIFTREG = {SHIFTREG[WIDTH-STEP-1:0], D_OUT}; SER_OUT = old SHIFTREG[WIDTH-1:WIDTH-STEP].
  - SHIFT_CNT increments by 1.
  - FULL is a registered flag. It rises on the same edge at which SHIFT_CNT becomes NSHIFT, so it is visible the cycle after the NSHIFT-th shift is sampled.
- SFT_IN with FULL high:
  - SHIFTREG, SER_OUT and SHIFT_CNT hold; this is a rejected shift.
  - OVF is set to 1 and stays set until RST, CLR_ACC or LOAD.
- No enables active: all state holds.
- Latency: SHIFTREG, SER_OUT and SHIFT_CNT all reflect a shift one edge after the cycle in which SFT_IN is sampled high. There is no combinational path from inputs to outputs.
- SHIFT_CNT never exceeds NSHIFT and never wraps.
- RST asserted mid-sequence aborts immediately; after release, the block behaves as freshly cleared.
- D_OUT and LOAD_DATA are don't-care when their enables are low.

Test Plan:
- Reset, then WIDTH=8/STEP=1/DIR=0; CLR_ACC; 8 shifts of D_OUT=1,0,1,1,0,0,1,0 → SHIFTREG=8'b01001101, SHIFT_CNT=8, FULL=1 one edge after the 8th sampled shift, OVF=0.
- Continue: ninth SFT_IN with D_OUT=1 → SHIFTREG stays 8'b01001101, OVF=1. Then CLR_ACC → all zero.
- LOAD_DATA=8'hA5 with LOAD and SFT_IN together → SHIFTREG=8'hA5, SHIFT_CNT=0. Then one shift with D_OUT=0 → SHIFTREG=8'h52, SER_OUT=1.
- WIDTH=8/STEP=2/DIR=1: CLR_ACC; 4 shifts of D_OUT=2'b11,2'b00,2'b10,2'b01 → SHIFTREG=8'b11001001, FULL=1 after exactly 4 shifts.
- Assert RST asynchronously (between edges) after 3 shifts → all outputs are 0 before the next edge. After release, 8 fresh shifts fill normally.
- CLR_ACC and LOAD asserted together with LOAD_DATA=8'hFF → SHIFTREG=0, proving CLR_ACC priority.
